// File: rtl/dw_sched_pkg.sv
// ---------------------------------------------------------------------------
// dw_sched_pkg
// Shared types and helpers for the depthwise weight scheduler.
//   sched_state_e : controller FSM states
//   wstride()     : byte distance between consecutive channels' weight blocks
// ---------------------------------------------------------------------------
package dw_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETADDR = 3'd1,
        S_LOAD    = 3'd2,
        S_FILL    = 3'd3,
        S_COMP    = 3'd4
    } sched_state_e;

    // One channel holds ksize*ksize weight words of dw bits each.
    function automatic int wstride(input int ksize, input int dw);
        return ksize * ksize * (dw / 8);
    endfunction

endpackage

// File: rtl/dw_weight_sched.sv
// ---------------------------------------------------------------------------
// dw_weight_sched
// Per-layer controller for the depthwise weight buffer. For every channel it
// loads the channel's weight start address into the buffer address generator,
// triggers the burst fetch, counts KSIZE*KSIZE beats into the buffer FIFO and
// then holds dw_comp until the PE array reports completion.
//
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   layer_start   : one-cycle pulse, latches base_addr / num_ch when idle
//   base_addr     : byte address of channel 0 weights
//   num_ch        : number of channels in the layer
//   layer_busy    : high while a layer is being served
//   layer_done    : one-cycle pulse at layer completion
//   init_addr     : channel weight address to the buffer
//   init_addr_en  : one-cycle load strobe for init_addr
//   weight_load   : one-cycle fetch trigger to the buffer
//   rvalid        : snoop of buffer read-data valid
//   dw_comp       : PE array may consume weights for cur_ch
//   comp_done     : one-cycle completion pulse from the PE array
//   cur_ch        : channel index being served
//   beat_err      : sticky, rvalid seen outside FILL
// All outputs are registered.
// ---------------------------------------------------------------------------
module dw_weight_sched
    import dw_sched_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int KSIZE = 3,
    parameter int CH_W  = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            layer_start,
    input  logic [AW-1:0]   base_addr,
    input  logic [CH_W-1:0] num_ch,
    output logic            layer_busy,
    output logic            layer_done,
    output logic [AW-1:0]   init_addr,
    output logic            init_addr_en,
    output logic            weight_load,
    input  logic            rvalid,
    output logic            dw_comp,
    input  logic            comp_done,
    output logic [CH_W-1:0] cur_ch,
    output logic            beat_err
);

    localparam int                BEATS     = KSIZE * KSIZE;
    localparam int                BCNT_W    = $clog2(BEATS + 1);
    localparam logic [AW-1:0]     STRIDE    = AW'(wstride(KSIZE, DW));
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);

    sched_state_e      state_q;
    logic [CH_W-1:0]   num_ch_q;
    logic [CH_W-1:0]   cur_ch_q;
    // ch_addr_q doubles as the init_addr output register.
    logic [AW-1:0]     ch_addr_q;
    logic [AW-1:0]     ch_addr_d;
    logic [BCNT_W-1:0] beat_q;
    logic              busy_q;
    logic              done_q;
    logic              init_en_q;
    logic              wload_q;
    logic              comp_q;
    logic              err_q;
    logic              last_ch;

    // Modulo 2^AW: the carry out is intentionally dropped.
    assign ch_addr_d = ch_addr_q + STRIDE;
    assign last_ch   = (cur_ch_q == (num_ch_q - CH_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            num_ch_q  <= '0;
            cur_ch_q  <= '0;
            ch_addr_q <= '0;
            beat_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            init_en_q <= 1'b0;
            wload_q   <= 1'b0;
            comp_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            // Strobes default low; they are raised for exactly one cycle.
            done_q    <= 1'b0;
            init_en_q <= 1'b0;
            wload_q   <= 1'b0;

            if (rvalid && (state_q != S_FILL)) begin
                err_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (layer_start) begin
                        // Accepting a start clears the sticky error, even if
                        // a stray beat arrives in the same cycle.
                        err_q <= 1'b0;
                        if (num_ch != '0) begin
                            num_ch_q  <= num_ch;
                            cur_ch_q  <= '0;
                            ch_addr_q <= base_addr;
                            busy_q    <= 1'b1;
                            init_en_q <= 1'b1;
                            state_q   <= S_SETADDR;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_SETADDR: begin
                    wload_q <= 1'b1;
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    beat_q  <= '0;
                    state_q <= S_FILL;
                end
                S_FILL: begin
                    if (rvalid) begin
                        beat_q <= beat_q + BCNT_W'(1);
                        if (beat_q == LAST_BEAT) begin
                            comp_q  <= 1'b1;
                            state_q <= S_COMP;
                        end
                    end
                end
                S_COMP: begin
                    if (comp_done) begin
                        comp_q <= 1'b0;
                        if (last_ch) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            cur_ch_q  <= cur_ch_q + CH_W'(1);
                            ch_addr_q <= ch_addr_d;
                            init_en_q <= 1'b1;
                            state_q   <= S_SETADDR;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign layer_busy   = busy_q;
    assign layer_done   = done_q;
    assign init_addr    = ch_addr_q;
    assign init_addr_en = init_en_q;
    assign weight_load  = wload_q;
    assign dw_comp      = comp_q;
    assign cur_ch       = cur_ch_q;
    assign beat_err     = err_q;

endmodule

// File: tb/tb_dw_weight_sched.sv
// ---------------------------------------------------------------------------
// tb_dw_weight_sched
// Directed, table-driven bench for dw_weight_sched (default parameters:
// AW=32, DW=32, KSIZE=3 -> 9 beats and a 0x24-byte stride per channel).
// ---------------------------------------------------------------------------
module tb_dw_weight_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        layer_start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [9:0]  num_ch = '0;
    logic        layer_busy;
    logic        layer_done;
    logic [31:0] init_addr;
    logic        init_addr_en;
    logic        weight_load;
    logic        rvalid = 1'b0;
    logic        dw_comp;
    logic        comp_done = 1'b0;
    logic [9:0]  cur_ch;
    logic        beat_err;

    dw_weight_sched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .layer_start  (layer_start),
        .base_addr    (base_addr),
        .num_ch       (num_ch),
        .layer_busy   (layer_busy),
        .layer_done   (layer_done),
        .init_addr    (init_addr),
        .init_addr_en (init_addr_en),
        .weight_load  (weight_load),
        .rvalid       (rvalid),
        .dw_comp      (dw_comp),
        .comp_done    (comp_done),
        .cur_ch       (cur_ch),
        .beat_err     (beat_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]      base;
        logic [9:0]       nch;
        logic             gappy;
        logic             spur;
        logic [3:0][31:0] exp;
    } vec_t;

    vec_t vt [6];
    // Gaps before each of the 9 beats: 11 idle cycles, 20 cycles in total.
    int   gaps [9] = '{0, 2, 0, 3, 1, 0, 4, 1, 0};

    int n_vec = 0;
    int n_err = 0;
    int n_ien, n_wl, n_done, n_busy;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance one clock and sample outputs 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (init_addr_en) n_ien++;
        if (weight_load)  n_wl++;
        if (layer_done)   n_done++;
        if (layer_busy)   n_busy++;
    endtask

    task automatic run_layer(input vec_t v, input int rst_at_ch);
        int gap;
        n_ien = 0; n_wl = 0; n_done = 0; n_busy = 0;
        base_addr   = v.base;
        num_ch      = v.nch;
        layer_start = 1'b1;
        tick();
        layer_start = 1'b0;
        chk("busy_c1", 64'(layer_busy), 64'(v.nch != 0));
        chk("ien_c1", 64'(init_addr_en), 64'(v.nch != 0));
        chk("err_clr", 64'(beat_err), 64'd0);
        if (v.nch == 0) begin
            chk("done_empty_c1", 64'(layer_done), 64'd1);
            repeat (3) tick();
            chk("empty_ien_cnt", 64'(n_ien), 64'd0);
            chk("empty_wl_cnt", 64'(n_wl), 64'd0);
            chk("empty_busy_cnt", 64'(n_busy), 64'd0);
            chk("empty_done_cnt", 64'(n_done), 64'd1);
            return;
        end
        for (int c = 0; c < int'(v.nch); c++) begin
            chk("init_addr", 64'(init_addr), 64'(v.exp[c]));
            chk("cur_ch", 64'(cur_ch), 64'(c));
            tick();
            chk("wload", 64'(weight_load), 64'd1);
            tick();
            if (v.spur && c == 0) begin
                layer_start = 1'b1;
                comp_done   = 1'b1;
                base_addr   = 32'hDEAD_0000;
                tick();
                layer_start = 1'b0;
                comp_done   = 1'b0;
                chk("spur_fill_busy", 64'(layer_busy), 64'd1);
                chk("spur_fill_ch", 64'(cur_ch), 64'd0);
                chk("spur_fill_comp", 64'(dw_comp), 64'd0);
            end
            for (int b = 0; b < 9; b++) begin
                if (rst_at_ch == c && b == 3) begin
                    rst_n = 1'b0;
                    #2;
                    chk("rst_outs", 64'({layer_busy, layer_done, init_addr_en, weight_load,
                                         dw_comp, beat_err, init_addr, cur_ch}), 64'd0);
                    return;
                end
                gap = v.gappy ? gaps[b] : 0;
                for (int g = 0; g < gap; g++) begin
                    tick();
                    chk("comp_early", 64'(dw_comp), 64'd0);
                end
                rvalid = 1'b1;
                tick();
                rvalid = 1'b0;
                chk("comp_at_beat", 64'(dw_comp), 64'(b == 8));
            end
            for (int k = 0; k < 4; k++) begin
                if (v.spur && k == 1) rvalid = 1'b1;
                tick();
                rvalid = 1'b0;
                chk("comp_hold", 64'(dw_comp), 64'd1);
                if (v.spur && k == 1) begin
                    chk("spur_err", 64'(beat_err), 64'd1);
                    chk("spur_comp_busy", 64'(layer_busy), 64'd1);
                end
            end
            comp_done = 1'b1;
            tick();
            comp_done = 1'b0;
            chk("comp_fall", 64'(dw_comp), 64'd0);
            if (c == int'(v.nch) - 1) begin
                chk("done_pulse", 64'(layer_done), 64'd1);
                chk("busy_fall", 64'(layer_busy), 64'd0);
            end else begin
                chk("next_ien", 64'(init_addr_en), 64'd1);
            end
        end
        tick();
        tick();
        chk("done_cnt", 64'(n_done), 64'd1);
        chk("ien_cnt", 64'(n_ien), 64'(v.nch));
        chk("wl_cnt", 64'(n_wl), 64'(v.nch));
        chk("err_end", 64'(beat_err), 64'(v.spur));
        chk("busy_end", 64'(layer_busy), 64'd0);
    endtask

    initial begin
        vt[0] = '{base: 32'h0000_1000, nch: 10'd3, gappy: 1'b0, spur: 1'b0,
                  exp: {32'h0, 32'h0000_1048, 32'h0000_1024, 32'h0000_1000}};
        vt[1] = '{base: 32'h0000_0000, nch: 10'd0, gappy: 1'b0, spur: 1'b0,
                  exp: {32'h0, 32'h0, 32'h0, 32'h0}};
        vt[2] = '{base: 32'h0000_2000, nch: 10'd1, gappy: 1'b1, spur: 1'b0,
                  exp: {32'h0, 32'h0, 32'h0, 32'h0000_2000}};
        vt[3] = '{base: 32'hFFFF_FFF0, nch: 10'd2, gappy: 1'b0, spur: 1'b0,
                  exp: {32'h0, 32'h0, 32'h0000_0014, 32'hFFFF_FFF0}};
        vt[4] = '{base: 32'h0000_4000, nch: 10'd2, gappy: 1'b1, spur: 1'b1,
                  exp: {32'h0, 32'h0, 32'h0000_4024, 32'h0000_4000}};
        vt[5] = '{base: 32'h0000_0100, nch: 10'd4, gappy: 1'b0, spur: 1'b0,
                  exp: {32'h0000_016C, 32'h0000_0148, 32'h0000_0124, 32'h0000_0100}};

        #1 rst_n = 1'b0;
        tick();
        tick();
        chk("reset_outs", 64'({layer_busy, layer_done, init_addr_en, weight_load,
                               dw_comp, beat_err, init_addr, cur_ch}), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_layer(vt[i], -1);
            tick();
        end

        // Reset during the fill of channel 1, then a clean layer from channel 0.
        run_layer(vt[0], 1);
        tick();
        chk("rst_held_busy", 64'(layer_busy), 64'd0);
        rst_n = 1'b1;
        tick();
        run_layer(vt[0], -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
